// File: rtl/console_tx.sv
// Console output stage for the tohost port: decodes print/power-off stores,
// buffers characters in a circular queue and serializes them as 8N1 frames.
module console_tx #(
  parameter int BAUD_DIV    = 723,
  parameter int QUEUE_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_x,
  input  logic                         i_we,
  input  logic [31:0]                  i_data,
  input  logic                         i_stall,
  output logic                         o_txd,
  output logic [$clog2(QUEUE_DEPTH):0] o_count,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic                         o_poweroff,
  output logic                         o_drained
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d, ovf_q, ovf_d, pwr_q, pwr_d;

  logic accept, push_req, push, pop, full, baud_end;
  logic unused_data;

  assign unused_data = ^{i_data[31:18], i_data[15:8]};

  always_comb begin
    accept   = i_we & ~i_stall;
    push_req = accept && (i_data[17:16] == 2'd1);
    baud_end = (baud_q == BW'(BAUD_DIV - 1));
    full     = (count_q == CW'(QUEUE_DEPTH));
    // A pop frees a slot on the same edge, so a push into a full queue survives.
    pop      = (count_q != '0) &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
    push     = push_req && (!full || pop);

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_req & ~push);
    pwr_d = pwr_q | (accept && (i_data[17:16] == 2'd2));

    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = S_START;
          shift_d = mem[head_q];
          txd_d   = 1'b0;
        end
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      S_DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      default: if (baud_end) begin
        if (pop) begin
          state_d = S_START;
          shift_d = mem[head_q];
          txd_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= i_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      pwr_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      pwr_q   <= pwr_d;
    end
  end

  assign o_txd      = txd_q;
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_overflow = ovf_q;
  assign o_poweroff = pwr_q;
  assign o_drained  = pwr_q && (count_q == '0) && (state_q == S_IDLE);
endmodule

// File: doc/console_tx.md
# console_tx

Buffered console output stage that sits directly downstream of the core's memory-mapped tohost port. It decodes tohost store commands: print-character, power-off. Characters are queued in a circular buffer and serialized as 8N1 UART frames on the board TX pin. It raises a sticky power-off flag, and a drained flag once every queued character has left the wire.

## Interface
Parameters:
- BAUD_DIV, 723: clocks per UART bit (83.33 MHz / 115200); legal range ≥ 2.
- QUEUE_DEPTH, 64: character buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock (user-design clock from the memory controller).
- rst_x  in  1  reset, asynchronous, active-low.
- i_we  in  1  tohost store strobe, one cycle per store.
- i_data  in  32  tohost store data; [17:16] command, [7:0] character.
- i_stall  in  1  core stall; while high, i_we is ignored.
- o_txd  out  1  UART serial output, registered, idle high.
- o_count  out  $clog2(QUEUE_DEPTH)+1  characters currently queued.
- o_full  out  1  o_count == QUEUE_DEPTH.
- o_overflow  out  1  sticky; a print command was dropped.
- o_poweroff  out  1  sticky; power-off command received.
- o_drained  out  1  o_poweroff & queue empty & serializer IDLE.

## Operation
- Command accepted when i_we & !i_stall at a rising edge. Decode of i_data[17:16]:
  - 1: push i_data[7:0].
  - 2: set o_poweroff.
  - 0 and 3: ignored.
- Queue: head pointer, tail pointer and count register. Pointers are $clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
  - Push writes at tail and then increments tail.
  - Pop reads at head and then increments head.
- Push while full and no pop in the same cycle: the character is dropped, o_overflow is set, and pointers and count are unchanged.
- Push while full with a pop in the same edge: the push is accepted.
- Push and pop at the same edge: count is unchanged and both pointers advance.
- Serializer FSM: IDLE → START → DATA → STOP.
  - IDLE, count > 0: pop, load shift register, go to START. o_txd = 0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each. A 3-bit bit counter and a baud counter run 0..BAUD_DIV-1.
  - STOP: o_txd = 1 for BAUD_DIV cycles.
  - At the end of STOP: if count > 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- The serializer runs regardless of i_stall. o_poweroff does not halt transmission of characters already queued.
- Reset values (asynchronous on rst_x low):
  - o_txd = 1; FSM IDLE.
  - Pointers, count and all counters = 0.
  - o_overflow = 0, o_poweroff = 0, o_drained = 0, o_full = 0.
  - A frame in flight is abandoned. Queue contents are discarded; RAM contents need no reset.

## Timing
- i_we/i_stall registered decode: command in cycle 0 → o_count increments in cycle 1, o_poweroff = 1 in cycle 1.
- First character into an empty queue: push sampled end of cycle 0; pop at end of cycle 1; o_txd = 0 from cycle 2.
- Frame length exactly 10·BAUD_DIV cycles. Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- o_count, o_full and o_drained come from registers or from registered state only; no combinational path from i_we.
- o_drained rises in the cycle after the final stop bit ends.

## Test plan
- BAUD_DIV=4: store 0x0001_0041 ('A') once → o_txd low cycles 2-5, then bits 1,0,0,0,0,0,1,0 (4 cycles each), high cycles 38-41, then IDLE; o_count returns to 0.
- QUEUE_DEPTH=4, BAUD_DIV=4: 6 consecutive print stores of 0x30..0x35 → 0x30 popped immediately; 0x31-0x34 queued; 0x35 dropped with o_overflow=1; wire carries 0x30..0x34 back-to-back, exactly 200 cycles from the first start bit to the end of the last stop bit.
- Print store with i_stall=1 → no push, o_count stays 0, o_txd stays 1; the same store repeated with i_stall=0 is accepted.
- Store 0x0001_0058 then 0x0002_0000 → o_poweroff=1 in the cycle after the second store; o_drained=0 until the 'X' stop bit completes, then 1. Commands 0 and 3 → no state change.
- Full queue (QUEUE_DEPTH=4) with a push coinciding with a pop at end of STOP → push accepted, o_count stays 4, o_overflow stays 0.
- Assert rst_x low mid-DATA → o_txd=1 immediately (asynchronous); o_count=0 and o_poweroff=0; after release a new print transmits correctly with no stale characters.
